// File: rtl/div_sched.sv
// Time-sliced round-robin scheduler granting one of four requesters per programmable slice.
// Optional build macro DIV_SCHED_PRIO_EN makes requester 0 win every arbitration it enters.
module div_sched #(
  parameter int N_REQ = 4,
  parameter int CNT_W = 14
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_REQ-1:0] req,
  input  logic [N_REQ-1:0] done,
  input  logic             cfg_load,
  input  logic [CNT_W-1:0] cfg_period,
  output logic [N_REQ-1:0] gnt,
  output logic [1:0]       gnt_id,
  output logic             busy,
  output logic             slice_end,
  output logic [CNT_W-1:0] count
);

  // Handshake: req is a level held by the requester; gnt is a registered one-hot
  // that stays high until terminal count, done[gnt_id], or req[gnt_id] dropping.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } state_t;

  state_t           state, state_n;
  logic [CNT_W-1:0] period_q, p_active;
  logic [1:0]       ptr;
  logic [1:0]       sel, idx;
  logic             any_req, slice_done;

  logic [N_REQ-1:0] gnt_n;
  logic [1:0]       gnt_id_n, ptr_n;
  logic [CNT_W-1:0] count_n, p_active_n;
  logic             slice_end_n;

  assign any_req    = |req;
  assign slice_done = (count == p_active) || done[gnt_id] || !req[gnt_id];
  assign busy       = |gnt;

  // Walk offsets from high to low so the smallest offset above ptr wins.
  always_comb begin
    sel = ptr;
    idx = ptr;
    for (int i = 3; i >= 0; i--) begin
      idx = ptr + 2'(i);
      if (req[idx]) sel = idx;
    end
`ifdef DIV_SCHED_PRIO_EN
    if (req[0]) sel = 2'd0;
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (any_req) state_n = GRANT;
      GRANT:   if (slice_done) state_n = GAP;
      GAP:     state_n = any_req ? GRANT : IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    gnt_n       = gnt;
    gnt_id_n    = gnt_id;
    count_n     = count;
    ptr_n       = ptr;
    p_active_n  = p_active;
    slice_end_n = 1'b0;
    case (state)
      IDLE, GAP: begin
        gnt_n   = '0;
        count_n = '0;
        if (any_req) begin
          gnt_n[sel] = 1'b1;
          gnt_id_n   = sel;
          p_active_n = period_q;
        end
      end
      GRANT: begin
        if (slice_done) begin
          gnt_n       = '0;
          count_n     = '0;
          ptr_n       = gnt_id + 2'd1;
          slice_end_n = 1'b1;
        end else begin
          count_n = count + 1'b1;
        end
      end
      default: begin
        gnt_n   = '0;
        count_n = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      gnt       <= '0;
      gnt_id    <= 2'd0;
      count     <= '0;
      ptr       <= 2'd0;
      p_active  <= '1;
      slice_end <= 1'b0;
      period_q  <= '1;
    end else begin
      gnt       <= gnt_n;
      gnt_id    <= gnt_id_n;
      count     <= count_n;
      ptr       <= ptr_n;
      p_active  <= p_active_n;
      slice_end <= slice_end_n;
      if (cfg_load) period_q <= cfg_period;
    end
  end

endmodule

// File: tb/tb_div_sched.sv
// Directed bench for div_sched: reset, rotation, early release, config timing, priority, reset mid-slice.
module tb_div_sched;
  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req, done;
  logic        cfg_load;
  logic [13:0] cfg_period;
  logic [3:0]  gnt;
  logic [1:0]  gnt_id;
  logic        busy, slice_end;
  logic [13:0] count;

  int total = 0;
  int bad   = 0;
  logic [15:0] exp_q[$];

  always #5 clk = ~clk;

  div_sched dut (
    .clk(clk), .reset(reset), .req(req), .done(done),
    .cfg_load(cfg_load), .cfg_period(cfg_period),
    .gnt(gnt), .gnt_id(gnt_id), .busy(busy), .slice_end(slice_end), .count(count)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic load_period(input logic [13:0] p);
    cfg_period = p;
    cfg_load   = 1'b1;
    tick();
    cfg_load   = 1'b0;
  endtask

  // Waits for a grant (bounded), then measures how many cycles it stays high.
  task automatic run_slice(input string tag, output int id, output int len, output logic [3:0] g);
    int          waited;
    logic [13:0] c0;
    bit          cnt_ok;
    waited = 0; id = -1; len = 0; cnt_ok = 1'b1; g = '0;
    while (gnt == 4'b0 && waited < 20000) begin
      tick();
      waited++;
    end
    chk({tag, "_seen"}, (gnt != 4'b0), 1);
    if (gnt == 4'b0) return;
    id = int'(gnt_id);
    g  = gnt;
    chk({tag, "_start_no_pulse"}, slice_end, 0);
    c0 = count;
    while (gnt != 4'b0 && len < 20000) begin
      if (count !== c0 + 14'(len)) cnt_ok = 1'b0;
      len++;
      tick();
    end
    chk({tag, "_count_seq"}, cnt_ok, 1);
    chk({tag, "_gap_pulse"}, slice_end, 1);
    chk({tag, "_gap_count"}, count, 0);
  endtask

  task automatic expect_slice(input string tag, input int exp_id, input int exp_len);
    int         id, len;
    logic [3:0] g;
    run_slice(tag, id, len, g);
    chk({tag, "_id"}, id, exp_id);
    chk({tag, "_gnt"}, g, 4'b0001 << exp_id);
    chk({tag, "_len"}, len, exp_len);
  endtask

  initial begin
    int         id, len, exp_id;
    logic [3:0] g;
    reset = 1'b0; req = 4'b1111; done = 4'b0; cfg_load = 1'b0; cfg_period = '0;

    // Reset state with requests pending
    repeat (3) tick();
    chk("rst_gnt", gnt, 0);
    chk("rst_gnt_id", gnt_id, 0);
    chk("rst_busy", busy, 0);
    chk("rst_slice_end", slice_end, 0);
    chk("rst_count", count, 0);
    reset = 1'b1;
    tick();
    chk("first_gnt", gnt, 4'b0001);
    chk("first_busy", busy, 1);
    chk("first_count", count, 0);
    expect_slice("default_p", 0, 16384);

    // Full rotation with P=3
    req = 4'b0; reset = 1'b0;
    tick();
    reset = 1'b1;
    load_period(14'd3);
    req = 4'b1111;
    exp_q = {16'd0, 16'd1, 16'd2, 16'd3, 16'd0};
    for (int k = 0; k < 5; k++) expect_slice("rot", int'(exp_q.pop_front()), 4);
    req = 4'b0;
    tick();
    chk("rot_idle_gnt", gnt, 0);

    // Early release by done, with non-granted done bits ignored
    load_period(14'd10);
    req = 4'b0110;
    tick();
    chk("rel_gnt", gnt, 4'b0010);
    chk("rel_count0", count, 0);
    tick();
    done = 4'b0101;
    tick();
    chk("rel_ignored_done", gnt, 4'b0010);
    chk("rel_count2", count, 2);
    done = 4'b0010;
    tick();
    done = 4'b0;
    chk("rel_dropped", gnt, 0);
    chk("rel_pulse", slice_end, 1);
    expect_slice("rel_next", 2, 11);

    // Early release by req drop; pointer is at 3 now
    req = 4'b1000;
    tick();
    chk("reqdrop_gnt", gnt, 4'b1000);
    req = 4'b0;
    tick();
    chk("reqdrop_dropped", gnt, 0);
    chk("reqdrop_pulse", slice_end, 1);
    tick();
    chk("reqdrop_idle_pulse", slice_end, 0);

    // Load during a slice does not touch the running slice
    load_period(14'd5);
    req = 4'b0001;
    tick();
    chk("mid_gnt", gnt, 4'b0001);
    tick();
    tick();
    cfg_period = 14'd1; cfg_load = 1'b1;
    tick();
    cfg_load = 1'b0;
    run_slice("mid", id, len, g);
    chk("mid_len", len + 3, 6);
    expect_slice("mid_next", 0, 2);
    req = 4'b0;
    tick();

    // Load with grant issue uses old value; terminal and done coincide
    req = 4'b0001; cfg_period = 14'd4; cfg_load = 1'b1;
    tick();
    cfg_load = 1'b0;
    chk("same_gnt", gnt, 4'b0001);
    chk("same_count0", count, 0);
    tick();
    done = 4'b0001;
    tick();
    done = 4'b0;
    chk("same_dropped", gnt, 0);
    chk("same_pulse", slice_end, 1);
    expect_slice("same_next", 0, 5);
    req = 4'b0;
    tick();

    // Arbitration order with all requesting
    reset = 1'b0;
    tick();
    reset = 1'b1;
    load_period(14'd2);
    req = 4'b1111;
    for (int k = 0; k < 4; k++) begin
`ifdef DIV_SCHED_PRIO_EN
      exp_id = 0;
`else
      exp_id = k;
`endif
      expect_slice("prio", exp_id, 3);
    end

    // Reset mid-slice clears immediately and restores the default period
    tick();
    tick();
    reset = 1'b0;
    #1;
    chk("midrst_gnt", gnt, 0);
    chk("midrst_count", count, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_gnt_id", gnt_id, 0);
    chk("midrst_slice_end", slice_end, 0);
    tick();
    reset = 1'b1;
    tick();
    chk("postrst_gnt", gnt, 4'b0001);
    expect_slice("postrst", 0, 16384);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/div_sched.md
# div_sched

Time-sliced round-robin scheduler that shares one divided time base among up to four requesters. It contains a programmable slice counter, a 14-bit wrap-to-zero up-counter in the style of the divider. It grants one requester at a time for a slice of programmable length, then rotates to the next. It sits between the divider/time-base logic and the consumers that need exclusive timed access, such as display digits or shared peripherals.

## Interface
- `N_REQ`, 4, number of requesters; fixed at 4 in this revision so that `gnt_id` is 2 bits.
- `CNT_W`, 14, width of the slice counter and the period register.

- `clk`  in  1  single clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `req`  in  N_REQ  level requests, one bit per requester.
- `done`  in  N_REQ  early release; only the bit of the currently granted requester is honoured.
- `cfg_load`  in  1  one-cycle strobe that captures `cfg_period`.
- `cfg_period`  in  CNT_W  slice terminal count P; a slice lasts P+1 cycles.
- `gnt`  out  N_REQ  one-hot grant, registered.
- `gnt_id`  out  2  index of the granted requester; holds the last value when idle.
- `busy`  out  1  high while any grant is active.
- `slice_end`  out  1  one-cycle pulse on the cycle after a grant drops.
- `count`  out  CNT_W  current slice counter value.

## Operation
- **Reset values:**
  - `gnt`=0, `gnt_id`=0, `busy`=0, `slice_end`=0, `count`=0.
  - Period register = all ones (16383).
  - Rotation pointer = 0.
  - State = IDLE.
- **States:** IDLE, GRANT, GAP.
- **IDLE:**
  - `gnt`=0 and `count` holds 0.
  - If any `req` bit is set, select the first set bit searching upward from the rotation pointer, modulo 4.
  - Register the grant, clear `count`, and go to GRANT.
- **GRANT:**
  - `count` increments by 1 each cycle.
  - The slice ends at the first of three events:
    - `count`==P_active;
    - `done[gnt_id]`=1;
    - `req[gnt_id]`=0.
  - At slice end: `gnt` goes to 0, `count` goes to 0, the pointer becomes `gnt_id`+1 modulo 4, and the state moves to GAP.
- **GAP:**
  - Exactly one cycle with `gnt`=0 and `slice_end`=1.
  - Then arbitrate exactly as in IDLE: go to GRANT if any `req` bit is set, otherwise go to IDLE.
- **Period register:**
  - `cfg_load` captures `cfg_period` in any state.
  - P_active is latched from the period register when a grant is issued, so a load never alters a slice already in progress.
  - `cfg_period`=0 gives a 1-cycle slice.
- **Arithmetic:** `count` is CNT_W bits unsigned and wraps from all-ones to 0. Because P_active is at most all-ones, the terminal compare always fires first.
- **Simultaneous events:**
  - `cfg_load` in the same cycle as a grant issue: the grant uses the old value; the new value applies from the next slice.
  - Terminal count and `done` in the same cycle: a single slice end, with one `slice_end` pulse.
  - `done` bits for non-granted requesters are ignored.
- **Reset mid-slice:** all outputs return immediately to their reset values. The period register returns to all ones; a previously loaded value is lost.

## Timing
- **Grant latency:** `req` sampled at edge k gives `gnt` high after edge k.
- **Slice length:**
  - With no early release, `gnt` stays high for exactly P+1 cycles.
  - `count` runs 0..P during those cycles.
- **Slice end:**
  - `slice_end` is high for the one GAP cycle.
  - The earliest next grant appears 1 cycle after `gnt` drops.
- **Early release:** `done` or `req` drop sampled at edge k gives `gnt` low after edge k.
- **Throughput:** with all requesters active, the repeat period is 4·(P+2) cycles.

## Configuration
- **`DIV_SCHED_PRIO_EN` defined:**
  - Requester 0 is high priority: whenever it is requesting, it wins every arbitration in IDLE or GAP, regardless of the pointer.
  - It never pre-empts a slice in progress.
  - The pointer still updates after every slice.
- **`DIV_SCHED_PRIO_EN` undefined:** pure round-robin as described above.

## Test plan
- **Reset state:** reset low with `req`=4'b1111 -> all outputs are 0. Release reset -> `gnt`=4'b0001 one cycle later, and `gnt` stays high for 16384 cycles with no config load.
- **Full rotation:** load P=3, hold `req`=4'b1111 -> grants 0,1,2,3,0. Each grant lasts 4 cycles with a 1-cycle gap; `slice_end` pulses 4 times in 24 cycles.
- **Early release:** P=10, `req`=4'b0110, pulse `done[1]` at `count`=2 -> `gnt[1]` drops after 3 cycles, then `gnt[2]` is granted and runs the full 11 cycles.
- **Mid-slice config load:** P=5, `cfg_load` with 1 during a slice -> the current slice lasts 6 cycles and the next slice lasts 2 cycles.
- **Priority macro, defined:** with `DIV_SCHED_PRIO_EN`, P=2, `req`=4'b1111 -> the grant after every gap is requester 0 (sequence 0,0,0…).
- **Priority macro, undefined:** same stimulus without the macro -> sequence 0,1,2,3.
- **Reset mid-slice:** assert reset during a grant -> `gnt`, `count` and `busy` are 0 asynchronously. After release, the period is back to 16383.
